// File: rtl/usb_attach_ctrl.sv
// usb_attach_ctrl: holds the host core in reset until PLL lock is stable, then debounces device attach,
// drives the USB bus reset, reports the device speed and detects disconnect.
module usb_attach_ctrl #(
  parameter int MS_CYCLES   = 12000,
  parameter int LOCK_HOLD   = 4096,
  parameter int DEBOUNCE_MS = 100,
  parameter int BUSRST_MS   = 10,
  parameter int RECOV_MS    = 10,
  parameter int DISC_CYCLES = 32
) (
  input  logic       usbclk,
  input  logic       usbrst,
  input  logic       pll_lock,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic       core_rst,
  output logic       drive_se0,
  output logic       attached,
  output logic       speed_low,
  output logic       disc_pulse,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DETACHED  = 3'd1,
    DEBOUNCE  = 3'd2,
    BUSRST    = 3'd3,
    RECOV     = 3'd4,
    ATTACHED  = 3'd5
  } st_t;
  st_t st, nxt;
  logic [1:0] lk_s, dp_s, dm_s;
  logic [15:0] pre, cnt;
  logic [7:0] ms;
  logic lk, dp, dm, se0, jls, tick, restart, clr, cnt_en, cand_low;
  assign lk = lk_s[1];
  assign dp = dp_s[1];
  assign dm = dm_s[1];
  assign se0 = dp == dm;
  assign jls = !dp && dm;
  assign tick = pre == 16'(MS_CYCLES - 1);
  always_comb begin
    nxt = st;
    restart = 1'b0;
    case (st)
      WAIT_LOCK: nxt = lk && cnt == 16'(LOCK_HOLD - 1) ? DETACHED : WAIT_LOCK;
      DETACHED:  nxt = se0 ? DETACHED : DEBOUNCE;
      DEBOUNCE: begin
        restart = !se0 && jls != cand_low;
        nxt = se0 ? DETACHED : !restart && tick && ms == 8'(DEBOUNCE_MS - 1) ? BUSRST : DEBOUNCE;
      end
      BUSRST:    nxt = tick && ms == 8'(BUSRST_MS - 1) ? RECOV : BUSRST;
      RECOV:     nxt = tick && ms == 8'(RECOV_MS - 1) ? ATTACHED : RECOV;
      ATTACHED:  nxt = se0 && cnt == 16'(DISC_CYCLES - 1) ? DETACHED : ATTACHED;
      default:   nxt = WAIT_LOCK;
    endcase
    if (!lk && st != WAIT_LOCK) nxt = WAIT_LOCK;
  end
  // Timebase restarts on every state entry and on a debounce restart so durations are exact
  assign clr = nxt != st || restart;
  assign cnt_en = st == WAIT_LOCK ? lk : st == ATTACHED && se0;
  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      lk_s <= '0;
      dp_s <= '0;
      dm_s <= '0;
      st <= WAIT_LOCK;
      pre <= '0;
      ms <= '0;
      cnt <= '0;
      cand_low <= 1'b0;
      speed_low <= 1'b0;
      disc_pulse <= 1'b0;
    end else begin
      lk_s <= {lk_s[0], pll_lock};
      dp_s <= {dp_s[0], dp_in};
      dm_s <= {dm_s[0], dm_in};
      st <= nxt;
      pre <= clr || tick ? '0 : pre + 16'd1;
      ms <= clr ? '0 : tick && ms != 8'hff ? ms + 8'd1 : ms;
      cnt <= clr || !cnt_en ? '0 : cnt + {15'd0, cnt != 16'hffff};
      cand_low <= (st == DETACHED && nxt == DEBOUNCE) || restart ? jls : cand_low;
      speed_low <= st == DEBOUNCE && nxt == BUSRST ? cand_low : st == ATTACHED && nxt == DETACHED ? 1'b0 : speed_low;
      disc_pulse <= st == ATTACHED && nxt == DETACHED;
    end
  end
  assign core_rst = st == WAIT_LOCK;
  assign drive_se0 = st == BUSRST;
  assign attached = st == ATTACHED;
  assign state = st;
endmodule

// File: tb/tb_usb_attach_ctrl.sv
// tb_usb_attach_ctrl: scoreboard bench for usb_attach_ctrl with shortened timing parameters.
module tb_usb_attach_ctrl;
  logic usbclk = 1'b0;
  logic usbrst, pll_lock, dp_in, dm_in;
  logic core_rst, drive_se0, attached, speed_low, disc_pulse;
  logic [2:0] state;
  typedef struct {
    int due;
    string tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int disc_n = 0;
  usb_attach_ctrl #(
    .MS_CYCLES(10), .LOCK_HOLD(8), .DEBOUNCE_MS(3), .BUSRST_MS(2), .RECOV_MS(2), .DISC_CYCLES(4)
  ) dut (
    .usbclk(usbclk), .usbrst(usbrst), .pll_lock(pll_lock), .dp_in(dp_in), .dm_in(dm_in),
    .core_rst(core_rst), .drive_se0(drive_se0), .attached(attached), .speed_low(speed_low),
    .disc_pulse(disc_pulse), .state(state)
  );
  always #5 usbclk = ~usbclk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (core_rst,drive_se0,attached,speed_low,disc_pulse,state[2:0])", tag, got, want);
    end
  endtask
  function automatic logic [7:0] v(input logic c, input logic d, input logic a, input logic s,
                                   input logic p, input logic [2:0] st);
    return {c, d, a, s, p, st};
  endfunction
  task automatic push_exp(input int d, input string tag, input logic [7:0] val);
    sb.push_back('{cyc + d, tag, val});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge usbclk);
  endtask
  task automatic line(input logic p, input logic m);
    dp_in = p;
    dm_in = m;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("sb_drained", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask
  // Starts from DETACHED with an idle SE0 line; presents the J state of the requested speed
  task automatic attach_seq(input logic low, input logic prev, input string tag);
    push_exp(2, {tag, "_det"}, v(0, 0, 0, prev, 0, 1));
    push_exp(3, {tag, "_deb"}, v(0, 0, 0, prev, 0, 2));
    push_exp(32, {tag, "_deb_end"}, v(0, 0, 0, prev, 0, 2));
    push_exp(33, {tag, "_busrst"}, v(0, 1, 0, low, 0, 3));
    push_exp(52, {tag, "_busrst_end"}, v(0, 1, 0, low, 0, 3));
    push_exp(53, {tag, "_recov"}, v(0, 0, 0, low, 0, 4));
    push_exp(72, {tag, "_recov_end"}, v(0, 0, 0, low, 0, 4));
    push_exp(73, {tag, "_attached"}, v(0, 0, 1, low, 0, 5));
    line(!low, low);
    tick(73);
  endtask
  task automatic disconnect(input logic se1, input logic spd, input string tag);
    push_exp(5, {tag, "_still"}, v(0, 0, 1, spd, 0, 5));
    push_exp(6, {tag, "_pulse"}, v(0, 0, 0, 0, 1, 1));
    push_exp(7, {tag, "_after"}, v(0, 0, 0, 0, 0, 1));
    line(se1, se1);
    tick(7);
  endtask
  always @(posedge usbclk) begin
    exp_t e;
    #2;
    cyc++;
    disc_n += int'(disc_pulse);
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, {core_rst, drive_se0, attached, speed_low, disc_pulse, state}, e.val);
    end
  end
  initial begin
    usbrst = 1'b1;
    pll_lock = 1'b0;
    line(0, 0);
    tick(1);
    push_exp(1, "reset", v(1, 0, 0, 0, 0, 0));
    push_exp(2, "reset_hold", v(1, 0, 0, 0, 0, 0));
    tick(2);
    usbrst = 1'b0;
    push_exp(10, "lock_glitch_restart", v(1, 0, 0, 0, 0, 0));
    push_exp(17, "lock_hold", v(1, 0, 0, 0, 0, 0));
    push_exp(18, "lock_done", v(0, 0, 0, 0, 0, 1));
    push_exp(25, "detached_se0", v(0, 0, 0, 0, 0, 1));
    pll_lock = 1'b1;
    tick(7);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(17);
    drain();
    attach_seq(1, 0, "ls");
    drain();
    push_exp(6, "se0x3_keep", v(0, 0, 1, 1, 0, 5));
    push_exp(12, "se0x3_keep_late", v(0, 0, 1, 1, 0, 5));
    line(0, 0);
    tick(3);
    line(0, 1);
    tick(12);
    drain();
    disconnect(0, 1, "disc_ls");
    drain();
    chk("disc_count_1", 8'(disc_n), 8'd1);
    attach_seq(0, 0, "fs");
    drain();
    disconnect(1, 0, "disc_se1");
    drain();
    push_exp(3, "flip_deb", v(0, 0, 0, 0, 0, 2));
    push_exp(20, "flip_pre", v(0, 0, 0, 0, 0, 2));
    push_exp(21, "flip_restart", v(0, 0, 0, 0, 0, 2));
    push_exp(35, "flip_no_early", v(0, 0, 0, 0, 0, 2));
    push_exp(50, "flip_deb_end", v(0, 0, 0, 0, 0, 2));
    push_exp(51, "flip_busrst", v(0, 1, 0, 1, 0, 3));
    push_exp(71, "flip_recov", v(0, 0, 0, 1, 0, 4));
    push_exp(91, "flip_attached", v(0, 0, 1, 1, 0, 5));
    line(1, 0);
    tick(18);
    line(0, 1);
    tick(73);
    drain();
    disconnect(0, 1, "disc_flip");
    drain();
    chk("disc_count_3", 8'(disc_n), 8'd3);
    push_exp(33, "ld_busrst", v(0, 1, 0, 1, 0, 3));
    push_exp(40, "ld_busrst_hold", v(0, 1, 0, 1, 0, 3));
    push_exp(41, "ld_wait_lock", v(1, 0, 0, 1, 0, 0));
    line(0, 1);
    tick(38);
    pll_lock = 1'b0;
    tick(3);
    line(0, 0);
    tick(2);
    pll_lock = 1'b1;
    push_exp(9, "ld_relock_hold", v(1, 0, 0, 1, 0, 0));
    push_exp(10, "ld_relock", v(0, 0, 0, 1, 0, 1));
    tick(10);
    drain();
    attach_seq(1, 1, "relock");
    drain();
    push_exp(1, "rst_mid", v(1, 0, 0, 0, 0, 0));
    usbrst = 1'b1;
    line(0, 0);
    tick(1);
    usbrst = 1'b0;
    push_exp(9, "rst_relock_hold", v(1, 0, 0, 0, 0, 0));
    push_exp(10, "rst_relock", v(0, 0, 0, 0, 0, 1));
    tick(10);
    drain();
    attach_seq(1, 0, "rst_recover");
    drain();
    chk("disc_total", 8'(disc_n), 8'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
